fir_mac_alu: RTL and testbench
==============================

# fir_mac_alu

Parametrised, pipelined arithmetic unit for the FIR core: the successor to the fixed 16-bit `alu`. Adds a valid/ready handshake, signed add, signed multiply and a tap-counting multiply-accumulate mode that emits one filter output per `TAPS` coefficient beats. It sits between the sample/coefficient fetch logic and the FIR output buffer.

## Interface
- `DATA_W`, 16: signed operand width for `a` and `b`.
- `ACC_W`, 40: signed result/accumulator width; legal only when `ACC_W >= 2*DATA_W + 1`.
- `TAPS`, 64: MAC beats per output frame; must be at least 2.
- `CNT_W`, $clog2(TAPS): tap counter width.

- `clk`  in  1  Rising-edge clock.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `in_valid`  in  1  Operand beat present.
- `in_ready`  out  1  Beat accepted when `in_valid && in_ready` at a rising edge.
- `a`  in  DATA_W  Signed operand (sample).
- `b`  in  DATA_W  Signed operand (coefficient).
- `select`  in  2  Operation: 00 ADD, 01 MUL, 10 MAC, 11 MAC_FLUSH.
- `out_valid`  out  1  `result` is valid.
- `out_ready`  in  1  Downstream accepts `result`.
- `result`  out  ACC_W  Signed result.
- `tap_count`  out  CNT_W  Number of MAC beats accumulated in the current frame.
- `overflow`  out  1  Sticky saturation flag; see Configuration.

## Operation
- Two-stage pipeline:
  - S1 registers `a`, `b`, `select` and a valid bit.
  - S2 computes the operation and drives the output register (`result`, `out_valid`).
- ADD: `result` = sext(a) + sext(b).
- MUL: `result` = sext(a*b), a full signed 2*DATA_W product.
- MAC, beat with `tap_count < TAPS-1`:
  - acc <= acc + sext(a*b), `tap_count` increments.
  - No output is produced.
- MAC, beat with `tap_count == TAPS-1`:
  - Emits `result` = acc + sext(a*b).
  - acc and `tap_count` clear to 0 in the same cycle.
- MAC_FLUSH: emits acc + sext(a*b) regardless of `tap_count`, then clears acc and `tap_count`.
- ADD and MUL beats interleaved with MAC beats leave acc and `tap_count` untouched.
- Arithmetic is two's complement, wrapping at ACC_W unless `ALU_SAT_EN` is defined.
- Stall:
  - `stall = out_valid && !out_ready`; `in_ready = !stall`.
  - While stalled, S1, S2, acc and `tap_count` all hold.
  - A non-emitting MAC beat in S2 does not create an output and does not stall.
- Reset (asynchronous, any time, including mid-frame):
  - `out_valid`=0, `result`=0, `tap_count`=0, acc=0, `overflow`=0, S1 valid=0.
  - In-flight beats are discarded.
  - `in_ready`=1 while reset is asserted and after release.

## Timing
- Latency: a beat accepted at edge N appears with `out_valid`=1 after edge N+2, provided there is no stall.
- Throughput is one beat per cycle with `out_ready` held at 1.
- `result` and `out_valid` hold stable until the cycle in which `out_ready`=1.
- `out_valid` drops at that edge unless a new emitting beat is completing in the same edge. In that case `out_valid` stays 1 and `result` is replaced.
- `in_ready` is combinational from `out_valid`/`out_ready`. There is no combinational path from `in_valid` to `in_ready`.
- `tap_count` updates on the edge at which the MAC beat leaves S2.

## Configuration
- `ALU_SAT_EN` defined:
  - Every ADD, MUL and accumulation result that exceeds the signed ACC_W range clamps to 2^(ACC_W-1)-1 or -2^(ACC_W-1).
  - `overflow` sets and stays set until reset.
- `ALU_SAT_EN` undefined:
  - Results wrap modulo 2^ACC_W.
  - `overflow` is tied to 0.

## Test plan
- Reset: assert `rst_n`=0 mid-stream with `tap_count`=3 -> all outputs 0 immediately, `in_ready`=1. After release, a MAC frame starts from `tap_count`=0.
- ADD/MUL, DATA_W=16: a=-5, b=7, ADD -> `result`=2, two cycles after acceptance. MUL -> -35. a=b=-32768, MUL -> 1073741824.
- MAC frame, TAPS=4: four MAC beats with a=1,2,3,4 and b=2 -> exactly one output, `result`=20. `tap_count` reads 0,1,2,3,0.
- Interleave and flush, TAPS=4: MAC(3,3), ADD(1,1), MAC_FLUSH(2,2) -> outputs 2, then 13, and `tap_count`=0 afterwards.
- Backpressure: hold `out_ready`=0 with an ADD result pending -> `in_ready`=0, `result` stable for 5 cycles, no beat lost. Release -> the queued results appear in order.
- Saturation, with `ALU_SAT_EN` defined, ACC_W=33, TAPS=64: 64 MAC beats of a=b=-32768 -> `result`=4294967295 and `overflow`=1. Without the macro, the same stimulus gives the wrapped value 0 and `overflow`=0.

Source files
------------

// File: rtl/fir_mac_alu.sv
// Pipelined signed ADD / MUL / tap-counting MAC unit for the FIR core with valid/ready handshake.
// Optional saturation with sticky overflow flag is enabled by defining ALU_SAT_EN.
module fir_mac_alu #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int TAPS   = 64,
  parameter int CNT_W  = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic [1:0]               select,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  result,
  output logic [CNT_W-1:0]         tap_count,
  output logic                     overflow
);

  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_MUL   = 2'b01,
    OP_MAC   = 2'b10,
    OP_FLUSH = 2'b11
  } op_t;

  logic                     stall;
  logic                     s1_valid;
  logic signed [DATA_W-1:0] s1_a;
  logic signed [DATA_W-1:0] s1_b;
  op_t                      s1_sel;
  logic                     s2_valid;
  op_t                      s2_sel;
  logic signed [ACC_W-1:0]  s2_opnd;
  logic signed [ACC_W-1:0]  acc;

  logic signed [PROD_W-1:0] prod;
  logic signed [DATA_W:0]   sum_ab;
  logic signed [ACC_W-1:0]  opnd_next;
  logic signed [ACC_W-1:0]  base;
  logic signed [ACC_W-1:0]  res_val;
  logic                     last_tap;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // S1 -> S2 forms the operand: the product (or a+b for ADD), already sign-extended to ACC_W.
  assign prod      = PROD_W'(s1_a) * PROD_W'(s1_b);
  assign sum_ab    = (DATA_W+1)'(s1_a) + (DATA_W+1)'(s1_b);
  assign opnd_next = (s1_sel == OP_ADD) ? ACC_W'(sum_ab) : ACC_W'(prod);

  // Only the MAC ops fold in the accumulator; ADD/MUL pass their operand through.
  assign base     = s2_sel[1] ? acc : '0;
  assign last_tap = (tap_count == CNT_W'(TAPS - 1));

`ifdef ALU_SAT_EN
  logic [ACC_W:0] wide;
  logic           ovf_hit;

  assign wide    = {base[ACC_W-1], base} + {s2_opnd[ACC_W-1], s2_opnd};
  assign ovf_hit = wide[ACC_W] ^ wide[ACC_W-1];
  assign res_val = !ovf_hit    ? wide[ACC_W-1:0] :
                   wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} :
                                 {1'b0, {(ACC_W-1){1'b1}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (!stall && s2_valid && ovf_hit) begin
      overflow <= 1'b1;
    end
  end
`else
  assign res_val  = base + s2_opnd;
  assign overflow = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_sel    <= OP_ADD;
      s2_valid  <= 1'b0;
      s2_sel    <= OP_ADD;
      s2_opnd   <= '0;
      acc       <= '0;
      tap_count <= '0;
      result    <= '0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid  <= in_valid;
      s1_a      <= a;
      s1_b      <= b;
      s1_sel    <= op_t'(select);
      s2_valid  <= s1_valid;
      s2_sel    <= s1_sel;
      s2_opnd   <= opnd_next;
      out_valid <= 1'b0;
      if (s2_valid) begin
        unique case (s2_sel)
          OP_ADD, OP_MUL: begin
            result    <= res_val;
            out_valid <= 1'b1;
          end
          OP_MAC: begin
            if (last_tap) begin
              result    <= res_val;
              out_valid <= 1'b1;
              acc       <= '0;
              tap_count <= '0;
            end else begin
              acc       <= res_val;
              tap_count <= tap_count + CNT_W'(1);
            end
          end
          OP_FLUSH: begin
            result    <= res_val;
            out_valid <= 1'b1;
            acc       <= '0;
            tap_count <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_alu.sv
// Scoreboard bench for fir_mac_alu: directed and random beats against an arithmetic model,
// plus a second instance (ACC_W=33, TAPS=64) for the saturation/wrap frame.
module tb_fir_mac_alu;

  localparam int DW  = 16;
  localparam int AW  = 40;
  localparam int TP  = 4;
  localparam int CW  = 2;
  localparam int AW2 = 33;
  localparam int TP2 = 64;
  localparam int CW2 = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 in_valid = 1'b0;
  logic                 out_ready = 1'b1;
  logic signed [DW-1:0] a = '0;
  logic signed [DW-1:0] b = '0;
  logic [1:0]           sel = 2'b00;
  logic                 in_ready;
  logic                 out_valid;
  logic signed [AW-1:0] result;
  logic [CW-1:0]        tap_count;
  logic                 overflow;

  logic                  in_valid2 = 1'b0;
  logic                  out_ready2 = 1'b1;
  logic signed [DW-1:0]  a2 = '0;
  logic signed [DW-1:0]  b2 = '0;
  logic [1:0]            sel2 = 2'b00;
  logic                  in_ready2;
  logic                  out_valid2;
  logic signed [AW2-1:0] result2;
  logic [CW2-1:0]        tap_count2;
  logic                  overflow2;

  fir_mac_alu #(.DATA_W(DW), .ACC_W(AW), .TAPS(TP), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .select(sel), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .tap_count(tap_count), .overflow(overflow)
  );

  fir_mac_alu #(.DATA_W(DW), .ACC_W(AW2), .TAPS(TP2), .CNT_W(CW2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .select(sel2), .out_valid(out_valid2), .out_ready(out_ready2),
    .result(result2), .tap_count(tap_count2), .overflow(overflow2)
  );

  int     checks = 0;
  int     failures = 0;
  longint exp_q[$];
  longint m_acc = 0;
  int     m_taps = 0;
  bit     rand_bp = 1'b0;

  // Reduce an exact integer to what a w-bit signed result register should hold.
  function automatic longint fit(input longint v, input int w);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
`ifdef ALU_SAT_EN
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
`else
    if (hi < lo) return 0;
    return (v <<< (64 - w)) >>> (64 - w);
`endif
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Frame-level behaviour: running sum of products, one output per TP MAC beats.
  task automatic model(input int aa, input int bb, input int s);
    longint p;
    p = longint'(aa) * longint'(bb);
    case (s)
      0: exp_q.push_back(fit(longint'(aa) + longint'(bb), AW));
      1: exp_q.push_back(fit(p, AW));
      2: begin
        m_acc = fit(m_acc + p, AW);
        m_taps++;
        if (m_taps == TP) begin
          exp_q.push_back(m_acc);
          m_acc  = 0;
          m_taps = 0;
        end
      end
      default: begin
        exp_q.push_back(fit(m_acc + p, AW));
        m_acc  = 0;
        m_taps = 0;
      end
    endcase
  endtask

  task automatic send(input int aa, input int bb, input int s);
    int n;
    a = DW'(aa);
    b = DW'(bb);
    sel = 2'(s);
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready stuck at %0d after %0d cycles, required 1", in_ready, n);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      model(aa, bb, s);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    cycles(4);
    check("drain_pending", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    longint e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got %0d expected no output", result);
      end else begin
        e = exp_q.pop_front();
        check("result", longint'(result), e);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic signed [DW-1:0] ra;
    logic signed [DW-1:0] rb;
    int n;

    cycles(3);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_tap_count", tap_count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    cycles(2);

    // Latency: accepted at edge N, visible after N+2.
    send(-5, 7, 0);
    @(posedge clk); #1 check("lat_n1_out_valid", out_valid, 0);
    @(posedge clk); #1 check("lat_n2_out_valid", out_valid, 1);
    send(-5, 7, 1);
    send(-32768, -32768, 1);
    drain();

    // TAPS=4 frame: 1*2+2*2+3*2+4*2 = 20.
    for (int i = 1; i <= 4; i++) begin
      check("frame_tap_count", tap_count, i - 1);
      send(i, 2, 2);
      cycles(3);
    end
    check("frame_tap_end", tap_count, 0);
    drain();

    // Interleave then flush: ADD gives 2, flush gives 9+4 = 13.
    send(3, 3, 2);
    send(1, 1, 0);
    send(2, 2, 3);
    drain();
    check("flush_tap_count", tap_count, 0);

    // Backpressure: three beats queued behind a held ADD result.
    out_ready = 1'b0;
    send(10, 20, 0);
    send(3, -4, 1);
    send(7, 7, 0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_in_ready", in_ready, 0);
      check("bp_result", result, 30);
    end
    out_ready = 1'b1;
    drain();

    // Reset mid-frame with tap_count=3 and an output pending.
    send(1, 1, 2);
    send(1, 1, 2);
    send(1, 1, 2);
    cycles(3);
    check("pre_rst_tap_count", tap_count, 3);
    out_ready = 1'b0;
    send(4, 4, 0);
    cycles(3);
    check("pre_rst_out_valid", out_valid, 1);
    a = 16'sd5; b = 16'sd5; sel = 2'b10; in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", result, 0);
    check("midrst_tap_count", tap_count, 0);
    check("midrst_in_ready", in_ready, 1);
    exp_q.delete();
    m_acc = 0;
    m_taps = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    cycles(2);
    rst_n = 1'b1;
    cycles(2);
    check("post_rst_tap_count", tap_count, 0);
    for (int i = 2; i <= 5; i++) send(i, -3, 2);
    drain();
    check("post_rst_frame_tap", tap_count, 0);

    // Random mix under random backpressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ra = DW'($urandom);
      rb = DW'($urandom);
      send(int'(ra), int'(rb), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) cycles(1);
    end
    rand_bp = 1'b0;
    cycles(2);
    out_ready = 1'b1;
    drain();
    check("rand_tap_count", tap_count, m_taps);
    send(0, 0, 3);
    drain();
    check("rand_overflow", overflow, 0);

    // 64 MAC beats of (-32768)^2 = 2^36: clamps to 2^32-1, or wraps to 0 at 33 bits.
    a2 = -16'sd32768; b2 = -16'sd32768; sel2 = 2'b10;
    in_valid2 = 1'b1;
    repeat (TP2) @(posedge clk);
    #1 in_valid2 = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("sat_out_valid", out_valid2, 1);
`ifdef ALU_SAT_EN
    check("sat_result", longint'(result2), 64'sd4294967295);
    check("sat_overflow", overflow2, 1);
`else
    check("sat_result", longint'(result2), 0);
    check("sat_overflow", overflow2, 0);
`endif
    check("sat_tap_count", tap_count2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
